// File: rtl/reg_shift_tx.sv
// reg_shift_tx: parallel-to-serial transmitter for register words.
// A word accepted on ld is shifted out MSB-first on sdo. Each bit lasts
// CLKDIV cycles. frame marks the data bits, bit_stb marks the last cycle
// of each bit, and done pulses once after the final bit. All outputs are
// registered and are computed from the next-state values, so they line up
// with the state they describe.
module reg_shift_tx #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  output logic             busy,
  output logic             frame,
  output logic             sdo,
  output logic             bit_stb,
  output logic             done
);

  // The divider needs at least one bit, even when CLKDIV=1.
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0]    divcnt_q, divcnt_d;
  logic             busy_q,   busy_d;
  logic             frame_q,  frame_d;
  logic             sdo_q,    sdo_d;
  logic             stb_q,    stb_d;
  logic             done_q,   done_d;

  // Next-state logic plus output values derived from the next state.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;

    case (state_q)
      S_IDLE: begin
        if (ld) begin
          shreg_d  = d;
          state_d  = S_SHIFT;
          bitcnt_d = '0;
          divcnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          shreg_d  = shreg_q << 1;
          if (bitcnt_q == BIT_LAST) begin
            // Hold the counter at its terminal value instead of wrapping.
            state_d = S_DONE;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    frame_d = (state_d == S_SHIFT);
    sdo_d   = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : 1'b1;
    stb_d   = (state_d == S_SHIFT) && (divcnt_d == DIV_LAST);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      busy_q   <= 1'b0;
      frame_q  <= 1'b0;
      sdo_q    <= 1'b1;
      stb_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
      sdo_q    <= sdo_d;
      stb_q    <= stb_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign frame   = frame_q;
  assign sdo     = sdo_q;
  assign bit_stb = stb_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reg_shift_tx.sv
// Testbench for reg_shift_tx: a CLKDIV=4 instance driven from a vector
// table plus hand-written sequences, and a CLKDIV=1 instance.
module tb_reg_shift_tx;

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        ld;
  logic        busy, frame, sdo, bit_stb, done;
  logic [15:0] d1;
  logic        ld1;
  logic        busy1, frame1, sdo1, bit_stb1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  reg_shift_tx #(.WIDTH(16), .CLKDIV(4)) dut4 (
    .clk(clk), .rst(rst), .d(d), .ld(ld),
    .busy(busy), .frame(frame), .sdo(sdo), .bit_stb(bit_stb), .done(done)
  );

  reg_shift_tx #(.WIDTH(16), .CLKDIV(1)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .ld(ld1),
    .busy(busy1), .frame(frame1), .sdo(sdo1), .bit_stb(bit_stb1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture state filled by observe()
  logic [15:0] cap_stream;   // sdo at each bit_stb
  logic [15:0] cap_sdo_fr;   // sdo in every frame cycle
  int cap_stb, cap_frame, cap_frame_first, cap_stb_in_frame;
  int cap_done, cap_done_at, cap_busy_low_at;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_bits;
    int          exp_frame;
    int          exp_done_at;
    int          exp_idle_at;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    cap_stream = '0; cap_sdo_fr = '0;
    cap_stb = 0; cap_frame = 0; cap_frame_first = 0; cap_stb_in_frame = 0;
    cap_done = 0; cap_done_at = 0; cap_busy_low_at = 0;
  endtask

  // Record one cycle (n = cycles since the accepting edge).
  task automatic observe(input int n, input logic b, input logic f,
                         input logic s, input logic st, input logic dn);
    if (f) begin
      cap_frame++;
      if (cap_frame_first == 0) cap_frame_first = n;
      cap_sdo_fr = {cap_sdo_fr[14:0], s};
      if (st) cap_stb_in_frame++;
    end
    if (st) begin
      cap_stb++;
      cap_stream = {cap_stream[14:0], s};
    end
    if (dn) begin
      cap_done++;
      cap_done_at = n;
    end
    if (!b && cap_busy_low_at == 0) cap_busy_low_at = n;
  endtask

  // Load one word on dut4, then scramble d, then watch until busy drops.
  task automatic run_word(input logic [15:0] din);
    clear_cap();
    d  = din;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    d  = ~din;
    for (int n = 1; n <= 200; n++) begin
      observe(n, busy, frame, sdo, bit_stb, done);
      if (!busy) break;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s_a, s_b;
    int rises, gap, nstb;
    logic prev_f;

    vecs[0] = '{16'hA5C3, 16'hA5C3, 64, 65, 66};
    vecs[1] = '{16'h0000, 16'h0000, 64, 65, 66};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 64, 65, 66};
    vecs[3] = '{16'h8001, 16'h8001, 64, 65, 66};
    vecs[4] = '{16'h5A3C, 16'h5A3C, 64, 65, 66};

    // ---- 1. Reset held with ld=1 ----
    rst = 1'b0; ld = 1'b1; d = 16'hFFFF; ld1 = 1'b0; d1 = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {27'd0, busy, frame, sdo, bit_stb, done}, 32'b00100);
      check("reset_outputs_div1", {27'd0, busy1, frame1, sdo1, bit_stb1, done1}, 32'b00100);
      $display("reset cycle %0d: busy=%b frame=%b sdo=%b stb=%b done=%b", i, busy, frame, sdo, bit_stb, done);
    end
    rst = 1'b1; ld = 1'b0;
    tick();
    check("post_reset_outputs", {27'd0, busy, frame, sdo, bit_stb, done}, 32'b00100);

    // ---- 2. Table-driven single words ----
    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i].din);
      check("word_bits", {16'd0, cap_stream}, {16'd0, vecs[i].exp_bits});
      check("word_stb_count", cap_stb, 16);
      check("word_frame_len", cap_frame, vecs[i].exp_frame);
      check("word_frame_first", cap_frame_first, 1);
      check("word_done_at", cap_done_at, vecs[i].exp_done_at);
      check("word_done_count", cap_done, 1);
      check("word_idle_at", cap_busy_low_at, vecs[i].exp_idle_at);
      $display("word d=%h: bits=%h frame=%0d done@%0d idle@%0d", vecs[i].din, cap_stream,
               cap_frame, cap_done_at, cap_busy_low_at);
    end

    // ---- 3. Loads while busy are ignored ----
    clear_cap();
    d = 16'h1234; ld = 1'b1;
    tick();
    ld = 1'b0; d = 16'hFFFF;
    for (int n = 1; n <= 200; n++) begin
      observe(n, busy, frame, sdo, bit_stb, done);
      if (!busy) break;
      ld = (bit_stb && cap_stb == 5) || done;
      tick();
      ld = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      if (busy || done) cap_done = cap_done + 100;
    end
    check("ignored_ld_bits", {16'd0, cap_stream}, 32'h1234);
    check("ignored_ld_done_count", cap_done, 1);
    check("ignored_ld_stays_idle", {31'd0, busy}, 32'd0);
    $display("ignored-load: bits=%h done_count=%0d", cap_stream, cap_done);

    // ---- 4. Continuous ld, alternating data ----
    s_a = '0; s_b = '0; rises = 0; gap = 0; nstb = 0; prev_f = 1'b0;
    d = 16'h0001; ld = 1'b1;
    tick();
    d = 16'h8000;
    for (int n = 1; n <= 300; n++) begin
      if (frame && !prev_f) begin
        rises++;
        if (rises == 2) ld = 1'b0;
      end
      if (!frame && rises == 1) gap++;
      if (bit_stb) begin
        if (nstb < 16) s_a = {s_a[14:0], sdo};
        else s_b = {s_b[14:0], sdo};
        nstb++;
      end
      prev_f = frame;
      if (nstb == 32 && !busy) break;
      tick();
    end
    ld = 1'b0;
    check("b2b_gap", gap, 2);
    check("b2b_frame_a", {16'd0, s_a}, 32'h0001);
    check("b2b_frame_b", {16'd0, s_b}, 32'h8000);
    check("b2b_stb_count", nstb, 32);
    $display("back-to-back: a=%h b=%h gap=%0d", s_a, s_b, gap);
    tick();

    // ---- 5. Reset in mid-transfer ----
    clear_cap();
    d = 16'hFFFF; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      observe(n, busy, frame, sdo, bit_stb, done);
      if (cap_stb == 7) break;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_outputs", {29'd0, busy, frame, sdo}, 32'b001);
    cap_done = 0;
    for (int n = 0; n < 70; n++) begin
      if (done || busy) cap_done++;
      tick();
    end
    check("midrst_no_done", cap_done, 0);
    run_word(16'h00FF);
    check("midrst_reload_bits", {16'd0, cap_stream}, 32'h00FF);
    check("midrst_reload_done_at", cap_done_at, 65);
    $display("mid-reset: reload bits=%h done@%0d", cap_stream, cap_done_at);

    // ---- 6. CLKDIV=1 instance ----
    clear_cap();
    d1 = 16'h8001; ld1 = 1'b1;
    tick();
    ld1 = 1'b0; d1 = 16'h0000;
    for (int n = 1; n <= 100; n++) begin
      observe(n, busy1, frame1, sdo1, bit_stb1, done1);
      if (!busy1) break;
      tick();
    end
    check("div1_frame_len", cap_frame, 16);
    check("div1_stb_in_frame", cap_stb_in_frame, 16);
    check("div1_sdo_per_cycle", {16'd0, cap_sdo_fr}, 32'h8001);
    check("div1_done_at", cap_done_at, 17);
    check("div1_idle_at", cap_busy_low_at, 18);
    $display("div1: sdo=%h frame=%0d stb=%0d done@%0d", cap_sdo_fr, cap_frame,
             cap_stb_in_frame, cap_done_at);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_shift_tx.md
Name: reg_shift_tx

Overview:
- Parallel-to-serial transmitter for 16-bit register contents.
- Accepts a word on a load strobe and shifts it out MSB-first on a single data line, with a frame qualifier and a per-bit sample strobe.
- Reads from the 16-bit data registers that the register write path fills. It sits on the microcontroller's debug/peripheral output side.

Parameters:
WIDTH, 16, word width in bits; legal range 2..32.
CLKDIV, 4, clock cycles per serial bit; legal range 1..255.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
d  input  WIDTH  word to transmit; sampled only on an accepted load.
ld  input  1  load request; accepted only when busy=0.
busy  output  1  high from the cycle after an accepted load through the DONE cycle inclusive.
frame  output  1  high while data bits are on sdo.
sdo  output  1  serial data, MSB first; idles high.
bit_stb  output  1  one-cycle pulse in the last cycle of each bit period (sample point).
done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset: rst=0 at a rising edge forces the following, regardless of state or transfer in progress:
  - state=IDLE, busy=0, frame=0, sdo=1, bit_stb=0, done=0;
  - shift register, bit counter and divider counter cleared.
- A partially sent word is abandoned with no done pulse.
- State machine: IDLE, SHIFT, DONE. All outputs are registered; no combinational path from ld or d to any output.
- IDLE:
  - busy=0, frame=0, sdo=1.
  - If ld=1 at an edge: shreg<=d, state<=SHIFT, bitcnt<=0, divcnt<=0.
- SHIFT:
  - busy=1, frame=1, sdo=shreg[WIDTH-1].
  - divcnt increments each cycle.
  - When divcnt=CLKDIV-1, bit_stb=1 in that same cycle, and at the edge: divcnt<=0, shreg<=shreg<<1 (zero-fill), bitcnt<=bitcnt+1.
  - When bitcnt=WIDTH-1 and divcnt=CLKDIV-1: state<=DONE.
- DONE:
  - busy=1, frame=0, sdo=1, done=1, for exactly one cycle; then state<=IDLE.
- Latency: ld accepted at edge E0.
  - frame is high for cycles E0+1 .. E0+WIDTH*CLKDIV.
  - done is high in cycle E0+WIDTH*CLKDIV+1.
  - The next load can be accepted at edge E0+WIDTH*CLKDIV+2.
- ld while busy=1 (SHIFT or DONE) is ignored; it is not queued and d is not sampled.
- ld held high continuously produces back-to-back words with exactly one DONE plus one IDLE cycle between frames.
- d may change freely after acceptance; transmitted data is the value at the accepting edge.
- CLKDIV=1: bit_stb is high every SHIFT cycle; each bit lasts one cycle.
- bitcnt width is clog2(WIDTH); divcnt width is clog2(CLKDIV) minimum 1. No wrap beyond the terminal values.
- rst=0 coinciding with ld=1: reset wins and the load is not accepted.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with ld=1, d=16'hFFFF -> busy=0, frame=0, sdo=1, bit_stb=0, done=0 throughout and one cycle after release.
2. Single word, CLKDIV=4, d=16'hA5C3: one-cycle ld ->
   - frame high 64 cycles;
   - sdo at the 16 bit_stb pulses reads 1010_0101_1100_0011;
   - done pulses at cycle 65 after acceptance;
   - busy low at cycle 66.
3. Ignored load: start 16'h1234, pulse ld with d=16'hFFFF at bit 5 and again during DONE -> serial stream is exactly 16'h1234, and only one done pulse.
4. Continuous ld=1, d alternating 16'h0001 then 16'h8000 at each acceptance ->
   - two frames separated by exactly 2 frame-low cycles;
   - bit streams are 0...01 and 10...0.
5. Mid-transfer reset: start 16'hFFFF, assert rst=0 for one cycle after the 7th bit_stb -> next cycle frame=0, sdo=1, busy=0, no done pulse; a new ld with 16'h00FF then transmits correctly.
6. CLKDIV=1 build, d=16'h8001 -> frame high 16 cycles, bit_stb high all 16, sdo=1 in cycles 1 and 16 and 0 otherwise, done in cycle 17.
